trap_ctrl: RTL and testbench

Trap and return sequencer between the MEM stage and the CSR register file. Collects exception flags, the `mret` indication and a synchronised external interrupt for the instruction in MEM, prioritises them, and drives the CSR file's `is_trap`/`is_mret`/`mepc`/`mcause`/`mtval` inputs. It then stalls the pipeline and redirects fetch to `mtvec` (trap) or to `mepc_o` (return), as read back from the CSR file.

---
 rtl/trap_ctrl.sv | 145 ++++++++++++++
 tb/tb_trap_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Trap/return sequencer between MEM and the CSR file: prioritises exceptions, interrupt and mret.
// Optional macro TRAP_VECTORED_EN enables vectored interrupt targets when mtvec[1:0]==2'b01.
module trap_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_m,
   input  logic [31:0] pc_m,
   input  logic [31:0] inst_m,
   input  logic [31:0] bad_addr_m,
   input  logic        exc_iam,
   input  logic        exc_ill,
   input  logic        exc_ecall,
   input  logic        exc_lam,
   input  logic        exc_sam,
   input  logic        mret_m,
   input  logic        ext_irq,
   input  logic [31:0] mstatus,
   input  logic [31:0] mtvec,
   input  logic [31:0] mepc_o,
   output logic        is_trap,
   output logic        is_mret,
   output logic [31:0] mepc,
   output logic [31:0] mcause,
   output logic [31:0] mtval,
   output logic        kill_m,
   output logic        stall,
   output logic        redirect,
   output logic [31:0] redirect_pc
);

   typedef enum logic [1:0] {IDLE, TRAP, RET, REDIR} state_t;

   state_t      state, state_nx;
   logic        irq_meta, irq_s;
   logic        irq_take, take_trap, take_ret;
   logic        from_ret;
   logic [31:0] cause_sel, tval_sel;
   logic [31:0] trap_base, vec_off;
   logic        unused_bits;

   assign unused_bits = ^{mstatus[31:4], mstatus[2:0], mtvec[1:0], mcause[30]};
   assign irq_take    = irq_s & mstatus[3] & valid_m;

   always_comb begin
      take_trap = 1'b0;
      cause_sel = '0;
      tval_sel  = '0;
      if (state == IDLE && valid_m) begin
         take_trap = 1'b1;
         if (irq_take) begin
            cause_sel = 32'h8000_000B;
         end else if (exc_iam) begin
            cause_sel = 32'd0;
            tval_sel  = bad_addr_m;
         end else if (exc_ill) begin
            cause_sel = 32'd2;
            tval_sel  = inst_m;
         end else if (exc_ecall) begin
            cause_sel = 32'd11;
         end else if (exc_lam) begin
            cause_sel = 32'd4;
            tval_sel  = bad_addr_m;
         end else if (exc_sam) begin
            cause_sel = 32'd6;
            tval_sel  = bad_addr_m;
         end else begin
            take_trap = 1'b0;
         end
      end
   end

   assign take_ret = (state == IDLE) & mret_m & valid_m & ~take_trap;
   assign kill_m   = rst & (take_trap | take_ret);

   always_comb begin
      state_nx = state;
      is_trap  = 1'b0;
      is_mret  = 1'b0;
      stall    = 1'b0;
      redirect = 1'b0;
      case (state)
         IDLE: begin
            if (take_trap)     state_nx = TRAP;
            else if (take_ret) state_nx = RET;
         end
         TRAP: begin
            is_trap  = 1'b1;
            stall    = 1'b1;
            state_nx = REDIR;
         end
         RET: begin
            is_mret  = 1'b1;
            stall    = 1'b1;
            state_nx = REDIR;
         end
         REDIR: begin
            stall    = 1'b1;
            redirect = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign trap_base = {mtvec[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
   assign vec_off = (mcause[31] && mtvec[1:0] == 2'b01) ? {mcause[29:0], 2'b00} : '0;
`else
   assign vec_off = '0;
`endif

   always_comb begin
      redirect_pc = RESET_PC;
      if (state == REDIR) redirect_pc = from_ret ? mepc_o : (trap_base + vec_off);
   end

   // mcause/mtval registers double as the last-trap copies replayed on mret
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         irq_meta <= 1'b0;
         irq_s    <= 1'b0;
         mepc     <= '0;
         mcause   <= '0;
         mtval    <= '0;
         from_ret <= 1'b0;
      end else begin
         state    <= state_nx;
         irq_meta <= ext_irq;
         irq_s    <= irq_meta;
         if (take_trap) begin
            mepc     <= pc_m;
            mcause   <= cause_sel;
            mtval    <= tval_sel;
            from_ret <= 1'b0;
         end else if (take_ret) begin
            mepc     <= mepc_o;
            from_ret <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus random transactions vs. a priority-table model.
module tb_trap_ctrl;

   localparam logic [31:0] RPC = 32'h0;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_m, exc_iam, exc_ill, exc_ecall, exc_lam, exc_sam, mret_m, ext_irq;
   logic [31:0] pc_m, inst_m, bad_addr_m, mstatus, mtvec, mepc_o;
   logic        is_trap, is_mret, kill_m, stall, redirect;
   logic [31:0] mepc, mcause, mtval, redirect_pc;

   int unsigned errors = 0;
   int unsigned checks = 0;

   logic [31:0] m_mepc = '0, m_mcause = '0, m_mtval = '0;

   trap_ctrl #(.RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst), .valid_m(valid_m), .pc_m(pc_m), .inst_m(inst_m),
      .bad_addr_m(bad_addr_m), .exc_iam(exc_iam), .exc_ill(exc_ill), .exc_ecall(exc_ecall),
      .exc_lam(exc_lam), .exc_sam(exc_sam), .mret_m(mret_m), .ext_irq(ext_irq),
      .mstatus(mstatus), .mtvec(mtvec), .mepc_o(mepc_o), .is_trap(is_trap), .is_mret(is_mret),
      .mepc(mepc), .mcause(mcause), .mtval(mtval), .kill_m(kill_m), .stall(stall),
      .redirect(redirect), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_ev();
      valid_m = 0; exc_iam = 0; exc_ill = 0; exc_ecall = 0; exc_lam = 0; exc_sam = 0; mret_m = 0;
   endtask

   // Idle cycles with no valid instruction; lets the irq synchroniser settle.
   task automatic idle(input int n);
      clear_ev();
      for (int i = 0; i < n; i++) begin
         cyc();
         chk("idle_stall", {31'b0, stall}, 32'd0);
         chk("idle_rpc", redirect_pc, RPC);
      end
   endtask

   // Reference decision straight from the priority table; irq is the settled ext_irq level.
   function automatic void decide(output bit trap, output bit ret, output logic [31:0] cause,
                                  output logic [31:0] tval, output bit intr);
      trap = 1; ret = 0; intr = 0; cause = '0; tval = '0;
      if (!valid_m)                 trap = 0;
      else if (ext_irq && mstatus[3]) begin cause = 32'h8000_000B; intr = 1; end
      else if (exc_iam)             begin cause = 0;  tval = bad_addr_m; end
      else if (exc_ill)             begin cause = 2;  tval = inst_m; end
      else if (exc_ecall)           begin cause = 11; end
      else if (exc_lam)             begin cause = 4;  tval = bad_addr_m; end
      else if (exc_sam)             begin cause = 6;  tval = bad_addr_m; end
      else                          trap = 0;
      if (!trap) ret = valid_m && mret_m;
   endfunction

   // Inputs for cycle N already driven; walks N..N+3 and checks each cycle.
   task automatic run_txn(input bit junk);
      bit trap, ret, intr;
      logic [31:0] cause, tval, exp_pc;
      decide(trap, ret, cause, tval, intr);
      #1;
      chk("kill_m", {31'b0, kill_m}, {31'b0, trap | ret});
      if (trap) begin
         m_mepc = pc_m; m_mcause = cause; m_mtval = tval;
         exp_pc = {mtvec[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
         if (intr && mtvec[1:0] == 2'b01) exp_pc = exp_pc + 32'h2C;
`endif
      end else if (ret) begin
         m_mepc = mepc_o;
         exp_pc = mepc_o;
      end else begin
         exp_pc = RPC;
      end
      cyc();
      if (junk && (trap || ret)) begin
         valid_m = $urandom_range(0, 1); exc_ill = $urandom_range(0, 1); exc_sam = $urandom_range(0, 1);
         mret_m = $urandom_range(0, 1); pc_m = $urandom;
      end
      chk("is_trap", {31'b0, is_trap}, {31'b0, trap});
      chk("is_mret", {31'b0, is_mret}, {31'b0, ret});
      chk("stall1", {31'b0, stall}, {31'b0, trap | ret});
      chk("mepc", mepc, m_mepc);
      chk("mcause", mcause, m_mcause);
      chk("mtval", mtval, m_mtval);
      if (trap || ret) begin
         cyc();
         chk("redirect", {31'b0, redirect}, 32'd1);
         chk("stall2", {31'b0, stall}, 32'd1);
         chk("strobe_off", {30'b0, is_trap, is_mret}, 32'd0);
         chk("redirect_pc", redirect_pc, exp_pc);
         cyc();
         chk("back_idle", {30'b0, stall, redirect}, 32'd0);
         chk("mcause_hold", mcause, m_mcause);
      end else begin
         chk("no_redirect_pc", redirect_pc, RPC);
      end
      clear_ev();
   endtask

   initial begin
      int pulses;
      clear_ev();
      rst = 0; ext_irq = 0; pc_m = 0; inst_m = 0; bad_addr_m = 0;
      mstatus = 0; mtvec = 0; mepc_o = 0;
      #3;
      chk("rst_strobes", {27'b0, is_trap, is_mret, kill_m, stall, redirect}, 32'd0);
      chk("rst_mepc", mepc, 32'd0);
      chk("rst_mcause", mcause, 32'd0);
      chk("rst_mtval", mtval, 32'd0);
      chk("rst_rpc", redirect_pc, RPC);
      #10 rst = 1;
      idle(2);

      // illegal instruction
      valid_m = 1; exc_ill = 1; inst_m = 32'hFFFF_FFFF; pc_m = 32'h100; mtvec = 32'h200;
      run_txn(0);
      chk("ill_target", m_mtval, 32'hFFFF_FFFF);

      // ecall then mret
      idle(1);
      valid_m = 1; exc_ecall = 1; pc_m = 32'h40; mtvec = 32'h200;
      run_txn(0);
      idle(1);
      valid_m = 1; mret_m = 1; mepc_o = 32'h40; pc_m = 32'h208;
      run_txn(0);

      // interrupt vs load-misaligned, enabled and masked
      ext_irq = 1; mstatus = 32'h8; idle(3);
      valid_m = 1; exc_lam = 1; pc_m = 32'h300; bad_addr_m = 32'h1003;
      run_txn(0);
      idle(1);
      mstatus = 0;
      valid_m = 1; exc_lam = 1; pc_m = 32'h304; bad_addr_m = 32'h1005;
      run_txn(0);

      // vectored mode base
      mstatus = 32'h8; mtvec = 32'h301; idle(1);
      valid_m = 1; pc_m = 32'h500;
      run_txn(0);
      ext_irq = 0; mstatus = 0; idle(3);

      // synchroniser latency: nothing after one edge, trap after two
      mstatus = 32'h8; valid_m = 1; pc_m = 32'h600; ext_irq = 1;
      #1 chk("irq_sync0", {31'b0, kill_m}, 32'd0);
      cyc();
      chk("irq_sync1", {31'b0, kill_m}, 32'd0);
      cyc();
      run_txn(0);
      ext_irq = 0; mstatus = 0; idle(3);

      // reset during TRAP
      valid_m = 1; exc_sam = 1; pc_m = 32'h700; bad_addr_m = 32'h2002;
      cyc();
      clear_ev();
      chk("pre_rst_trap", {31'b0, is_trap}, 32'd1);
      rst = 0;
      #1;
      chk("mid_rst_strobes", {27'b0, is_trap, is_mret, kill_m, stall, redirect}, 32'd0);
      chk("mid_rst_regs", mepc | mcause | mtval, 32'd0);
      m_mepc = '0; m_mcause = '0; m_mtval = '0;
      #3 rst = 1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("post_rst_quiet", {28'b0, is_trap, is_mret, stall, redirect}, 32'd0);
      end
      valid_m = 1; exc_iam = 1; pc_m = 32'h800; bad_addr_m = 32'h902; mtvec = 32'h400;
      run_txn(0);

      // exc_ill held through the whole sequence
      idle(1);
      valid_m = 1; exc_ill = 1; inst_m = 32'h0000_0013; pc_m = 32'h900;
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         if (is_trap) pulses++;
      end
      chk("held_ill_pulses", pulses, 32'd1);
      clear_ev();
      m_mepc = 32'h900; m_mcause = 2; m_mtval = 32'h0000_0013;
      idle(3);

      // random transactions
      for (int t = 0; t < 40; t++) begin
         ext_irq = ($urandom_range(0, 2) == 0);
         mstatus = $urandom;
         mtvec = $urandom;
         mepc_o = $urandom;
         idle(3);
         valid_m = ($urandom_range(0, 7) != 0);
         exc_iam = ($urandom_range(0, 4) == 0);
         exc_ill = ($urandom_range(0, 4) == 0);
         exc_ecall = ($urandom_range(0, 4) == 0);
         exc_lam = ($urandom_range(0, 4) == 0);
         exc_sam = ($urandom_range(0, 4) == 0);
         mret_m = ($urandom_range(0, 2) == 0);
         pc_m = $urandom; inst_m = $urandom; bad_addr_m = $urandom;
         run_txn(1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
